// File: rtl/ir_sense_seq.sv
// IR sensor conversion sequencer: periodically fires the IR emitters, converts
// NUM_CH A2D channels in turn and publishes a coherent result set.
//
// state  | meaning
// IDLE   | waiting for a period tick with en=1
// SETTLE | IR emitters on, waiting SETTLE_CYC clocks
// CONV   | strt_cnv pulse for the current slot
// GUARD  | ignore cnv_cmplt still high from the previous conversion
// WAIT   | waiting for cnv_cmplt, bounded by TMO_CYC
// DONE   | result set published, rnd_vld high
module ir_sense_seq #(
    parameter int NUM_CH     = 4,
    parameter int SETTLE_CYC = 1024,
    parameter int PERIOD_CYC = 65536,
    parameter int TMO_CYC    = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    output logic                  strt_cnv,
    output logic [2:0]            chnnl,
    input  logic                  cnv_cmplt,
    input  logic [11:0]           res,
    output logic                  IR_en,
    output logic [12*NUM_CH-1:0]  rd_all,
    output logic                  rnd_vld,
    output logic                  err
);

    localparam int RW = 12 * NUM_CH;
    localparam int PW = (PERIOD_CYC > 2) ? $clog2(PERIOD_CYC) : 1;
    localparam int SW = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;
    localparam int TW = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;

    localparam logic [PW-1:0] PER_LAST  = PW'(PERIOD_CYC - 1);
    localparam logic [SW-1:0] SET_LAST  = SW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TMO_CYC - 1);
    localparam logic [2:0]    SLOT_LAST = 3'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_CONV,
        S_GUARD,
        S_WAIT,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  per_q, per_d;
    logic [SW-1:0]  set_q, set_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic [2:0]     slot_q, slot_d;
    logic [RW-1:0]  shadow_q, shadow_d;
    logic           strt_cnv_q, strt_cnv_d;
    logic [2:0]     chnnl_q, chnnl_d;
    logic           ir_en_q, ir_en_d;
    logic [RW-1:0]  rd_all_q, rd_all_d;
    logic           rnd_vld_q, rnd_vld_d;
    logic           err_q, err_d;
    logic           tick;

    // Free-running period counter; held at zero while disabled.
    always_comb begin
        tick = (per_q == PER_LAST);
        if (!en || tick) begin
            per_d = '0;
        end else begin
            per_d = per_q + PW'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        set_d      = set_q;
        tmo_d      = tmo_q;
        slot_d     = slot_q;
        shadow_d   = shadow_q;
        strt_cnv_d = 1'b0;
        chnnl_d    = chnnl_q;
        ir_en_d    = ir_en_q;
        rd_all_d   = rd_all_q;
        rnd_vld_d  = 1'b0;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                if (tick && en) begin
                    state_d = S_SETTLE;
                    ir_en_d = 1'b1;
                    set_d   = '0;
                    slot_d  = '0;
                end
            end
            S_SETTLE: begin
                if (set_q == SET_LAST) begin
                    state_d    = S_CONV;
                    strt_cnv_d = 1'b1;
                    chnnl_d    = slot_q;
                end else begin
                    set_d = set_q + SW'(1);
                end
            end
            S_CONV: begin
                state_d = S_GUARD;
            end
            S_GUARD: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnv_cmplt) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (slot_q == 3'(i)) begin
                            shadow_d[12*i +: 12] = res;
                        end
                    end
                    // Publish on entry to DONE so rd_all and rnd_vld line up.
                    if (slot_q == SLOT_LAST) begin
                        state_d   = S_DONE;
                        rd_all_d  = shadow_d;
                        rnd_vld_d = 1'b1;
                    end else begin
                        slot_d     = slot_q + 3'd1;
                        state_d    = S_CONV;
                        strt_cnv_d = 1'b1;
                        chnnl_d    = slot_q + 3'd1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    ir_en_d = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_DONE: begin
                ir_en_d = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            per_q      <= '0;
            set_q      <= '0;
            tmo_q      <= '0;
            slot_q     <= '0;
            shadow_q   <= '0;
            strt_cnv_q <= 1'b0;
            chnnl_q    <= '0;
            ir_en_q    <= 1'b0;
            rd_all_q   <= '0;
            rnd_vld_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            per_q      <= per_d;
            set_q      <= set_d;
            tmo_q      <= tmo_d;
            slot_q     <= slot_d;
            shadow_q   <= shadow_d;
            strt_cnv_q <= strt_cnv_d;
            chnnl_q    <= chnnl_d;
            ir_en_q    <= ir_en_d;
            rd_all_q   <= rd_all_d;
            rnd_vld_q  <= rnd_vld_d;
            err_q      <= err_d;
        end
    end

    assign strt_cnv = strt_cnv_q;
    assign chnnl    = chnnl_q;
    assign IR_en    = ir_en_q;
    assign rd_all   = rd_all_q;
    assign rnd_vld  = rnd_vld_q;
    assign err      = err_q;

endmodule

// File: tb/tb_ir_sense_seq.sv
// Directed bench for ir_sense_seq with a behavioural A2D model (20-clock
// conversions, cnv_cmplt held until one clock after the next strt_cnv).
module tb_ir_sense_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        en2 = 1'b0;

    logic        strt_cnv, cnv_cmplt, ir_en, rnd_vld, err;
    logic [2:0]  chnnl;
    logic [11:0] res;
    logic [47:0] rd_all;

    logic        strt_cnv2, cnv_cmplt2, ir_en2, rnd_vld2, err2;
    logic [2:0]  chnnl2;
    logic [11:0] res2;
    logic [47:0] rd_all2;

    int nvec = 0;
    int nerr = 0;
    int n_strt = 0;
    int n_rnd = 0;

    logic [2:0]  blk_ch = 3'd7;
    logic [11:0] res_base = 12'h100;

    always #5 clk = ~clk;

    ir_sense_seq #(.NUM_CH(4), .SETTLE_CYC(8), .PERIOD_CYC(256), .TMO_CYC(64)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .strt_cnv(strt_cnv), .chnnl(chnnl),
        .cnv_cmplt(cnv_cmplt), .res(res), .IR_en(ir_en), .rd_all(rd_all),
        .rnd_vld(rnd_vld), .err(err)
    );

    ir_sense_seq #(.NUM_CH(4), .SETTLE_CYC(8), .PERIOD_CYC(64), .TMO_CYC(64)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en2), .strt_cnv(strt_cnv2), .chnnl(chnnl2),
        .cnv_cmplt(cnv_cmplt2), .res(res2), .IR_en(ir_en2), .rd_all(rd_all2),
        .rnd_vld(rnd_vld2), .err(err2)
    );

    // A2D model: done level 20 clocks after strt_cnv, cleared one clock after strt_cnv.
    int         a_cnt, b_cnt;
    logic       a_busy, a_clr, b_busy, b_clr;
    logic [2:0] a_ch, b_ch;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnv_cmplt <= 1'b0; res <= '0; a_cnt <= 0; a_busy <= 1'b0; a_clr <= 1'b0; a_ch <= '0;
        end else begin
            a_clr <= strt_cnv;
            if (a_clr) cnv_cmplt <= 1'b0;
            if (strt_cnv) begin
                a_busy <= 1'b1; a_cnt <= 19; a_ch <= chnnl;
            end else if (a_busy) begin
                if (a_cnt == 0) begin
                    a_busy <= 1'b0;
                    if (a_ch != blk_ch) begin
                        cnv_cmplt <= 1'b1;
                        res <= res_base + {9'd0, a_ch};
                    end
                end else begin
                    a_cnt <= a_cnt - 1;
                end
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnv_cmplt2 <= 1'b0; res2 <= '0; b_cnt <= 0; b_busy <= 1'b0; b_clr <= 1'b0; b_ch <= '0;
        end else begin
            b_clr <= strt_cnv2;
            if (b_clr) cnv_cmplt2 <= 1'b0;
            if (strt_cnv2) begin
                b_busy <= 1'b1; b_cnt <= 19; b_ch <= chnnl2;
            end else if (b_busy) begin
                if (b_cnt == 0) begin
                    b_busy <= 1'b0;
                    cnv_cmplt2 <= 1'b1;
                    res2 <= 12'h100 + {9'd0, b_ch};
                end else begin
                    b_cnt <= b_cnt - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (strt_cnv === 1'b1) n_strt++;
        if (rnd_vld === 1'b1) n_rnd++;
    end

    function automatic logic [47:0] exp_rd(input logic [11:0] base);
        logic [47:0] v;
        for (int i = 0; i < 4; i++) v[12*i +: 12] = base + 12'(i);
        return v;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; en2 = 1'b0;
        #1;
        nvec++; if (strt_cnv !== 1'b0) begin nerr++; $display("FAIL reset_strt_cnv: got %b want 0", strt_cnv); end
        nvec++; if (chnnl !== 3'd0) begin nerr++; $display("FAIL reset_chnnl: got %0d want 0", chnnl); end
        nvec++; if (ir_en !== 1'b0) begin nerr++; $display("FAIL reset_ir_en: got %b want 0", ir_en); end
        nvec++; if (rd_all !== 48'd0) begin nerr++; $display("FAIL reset_rd_all: got %h want 0", rd_all); end
        nvec++; if (rnd_vld !== 1'b0) begin nerr++; $display("FAIL reset_rnd_vld: got %b want 0", rnd_vld); end
        nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL reset_err: got %b want 0", err); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_normal();
        int n;
        @(negedge clk);
        en = 1'b1;
        n = 0; do begin @(negedge clk); n++; end while (ir_en !== 1'b1 && n < 400);
        nvec++; if (n != 256) begin nerr++; $display("FAIL normal_first_tick: got %0d clocks want 256", n); end
        n = 0; do begin @(negedge clk); n++; end while (strt_cnv !== 1'b1 && n < 50);
        nvec++; if (n != 8) begin nerr++; $display("FAIL normal_settle: got %0d clocks want 8", n); end
        nvec++; if (chnnl !== 3'd0) begin nerr++; $display("FAIL normal_chnnl0: got %0d want 0", chnnl); end
        for (int i = 1; i < 4; i++) begin
            n = 0; do begin @(negedge clk); n++; end while (strt_cnv !== 1'b1 && n < 100);
            nvec++; if (n != 22) begin nerr++; $display("FAIL normal_spacing%0d: got %0d want 22", i, n); end
            nvec++; if (chnnl !== 3'(i)) begin nerr++; $display("FAIL normal_chnnl%0d: got %0d want %0d", i, chnnl, i); end
        end
        n = 0; do begin @(negedge clk); n++; end while (rnd_vld !== 1'b1 && n < 100);
        nvec++; if (n != 22) begin nerr++; $display("FAIL normal_rnd_vld_time: got %0d want 22", n); end
        nvec++; if (rd_all !== 48'h103_102_101_100) begin nerr++; $display("FAIL normal_rd_all: got %h want 103102101100", rd_all); end
        @(negedge clk);
        nvec++; if (ir_en !== 1'b0) begin nerr++; $display("FAIL normal_ir_en_off: got %b want 0", ir_en); end
        nvec++; if (rnd_vld !== 1'b0) begin nerr++; $display("FAIL normal_rnd_vld_pulse: got %b want 0", rnd_vld); end
    endtask

    task automatic test_stale_cmplt();
        int n;
        int s0;
        res_base = 12'h200;
        n = 0; do begin @(negedge clk); n++; end while (ir_en !== 1'b1 && n < 300);
        nvec++; if (n >= 300) begin nerr++; $display("FAIL stale_round_start: got timeout want IR_en"); end
        s0 = n_strt;
        for (int i = 0; i < 4; i++) begin
            n = 0; do begin @(negedge clk); n++; end while (strt_cnv !== 1'b1 && n < 100);
            nvec++; if (n != ((i == 0) ? 8 : 22)) begin nerr++; $display("FAIL stale_spacing%0d: got %0d want %0d", i, n, (i == 0) ? 8 : 22); end
        end
        n = 0; do begin @(negedge clk); n++; end while (rnd_vld !== 1'b1 && n < 100);
        nvec++; if (rd_all !== exp_rd(12'h200)) begin nerr++; $display("FAIL stale_rd_all: got %h want %h", rd_all, exp_rd(12'h200)); end
        @(negedge clk);
        nvec++; if (n_strt - s0 != 4) begin nerr++; $display("FAIL stale_strt_count: got %0d want 4", n_strt - s0); end
    endtask

    task automatic test_timeout();
        int n;
        int r0;
        res_base = 12'h300;
        blk_ch = 3'd2;
        r0 = n_rnd;
        n = 0; do begin @(negedge clk); n++; end while (!(strt_cnv === 1'b1 && chnnl === 3'd2) && n < 400);
        nvec++; if (n >= 400) begin nerr++; $display("FAIL tmo_ch2_start: got timeout want strt on ch2"); end
        n = 0; do begin @(negedge clk); n++; end while (err !== 1'b1 && n < 100);
        nvec++; if (n != 66) begin nerr++; $display("FAIL tmo_err_time: got %0d want 66", n); end
        nvec++; if (ir_en !== 1'b0) begin nerr++; $display("FAIL tmo_ir_en: got %b want 0", ir_en); end
        repeat (30) @(negedge clk);
        nvec++; if (n_rnd != r0) begin nerr++; $display("FAIL tmo_no_rnd_vld: got %0d pulses want 0", n_rnd - r0); end
        nvec++; if (rd_all !== exp_rd(12'h200)) begin nerr++; $display("FAIL tmo_rd_all_kept: got %h want %h", rd_all, exp_rd(12'h200)); end
        blk_ch = 3'd7;
        n = 0; do begin @(negedge clk); n++; end while (ir_en !== 1'b1 && n < 300);
        nvec++; if (n >= 300) begin nerr++; $display("FAIL tmo_next_round: got timeout want IR_en"); end
        n = 0; do begin @(negedge clk); n++; end while (rnd_vld !== 1'b1 && n < 200);
        nvec++; if (rd_all !== exp_rd(12'h300)) begin nerr++; $display("FAIL tmo_recover_rd_all: got %h want %h", rd_all, exp_rd(12'h300)); end
        nvec++; if (err !== 1'b1) begin nerr++; $display("FAIL tmo_err_sticky: got %b want 1", err); end
    endtask

    task automatic test_en_drop();
        int n;
        int s0;
        res_base = 12'h400;
        n = 0; do begin @(negedge clk); n++; end while (!(strt_cnv === 1'b1 && chnnl === 3'd1) && n < 400);
        nvec++; if (n >= 400) begin nerr++; $display("FAIL endrop_ch1_start: got timeout want strt on ch1"); end
        repeat (3) @(negedge clk);
        en = 1'b0;
        n = 0; do begin @(negedge clk); n++; end while (rnd_vld !== 1'b1 && n < 200);
        nvec++; if (n >= 200) begin nerr++; $display("FAIL endrop_rnd_vld: got none want pulse"); end
        nvec++; if (rd_all !== exp_rd(12'h400)) begin nerr++; $display("FAIL endrop_rd_all: got %h want %h", rd_all, exp_rd(12'h400)); end
        @(negedge clk);
        s0 = n_strt;
        repeat (768) @(negedge clk);
        nvec++; if (n_strt != s0) begin nerr++; $display("FAIL endrop_no_new_round: got %0d strt want 0", n_strt - s0); end
        nvec++; if (ir_en !== 1'b0) begin nerr++; $display("FAIL endrop_ir_en: got %b want 0", ir_en); end
    endtask

    task automatic test_reset_mid_round();
        int n;
        res_base = 12'h500;
        @(negedge clk);
        en = 1'b1;
        n = 0; do begin @(negedge clk); n++; end while (ir_en !== 1'b1 && n < 400);
        nvec++; if (n != 256) begin nerr++; $display("FAIL rstmid_first_tick: got %0d want 256", n); end
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        nvec++; if (ir_en !== 1'b0) begin nerr++; $display("FAIL rstmid_ir_en: got %b want 0", ir_en); end
        nvec++; if (chnnl !== 3'd0) begin nerr++; $display("FAIL rstmid_chnnl: got %0d want 0", chnnl); end
        nvec++; if (rd_all !== 48'd0) begin nerr++; $display("FAIL rstmid_rd_all: got %h want 0", rd_all); end
        nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL rstmid_err: got %b want 0", err); end
        nvec++; if (strt_cnv !== 1'b0 || rnd_vld !== 1'b0) begin nerr++; $display("FAIL rstmid_pulses: got %b%b want 00", strt_cnv, rnd_vld); end
        @(negedge clk);
        rst_n = 1'b1;
        n = 0; do begin @(negedge clk); n++; end while (ir_en !== 1'b1 && n < 400);
        nvec++; if (n != 256) begin nerr++; $display("FAIL rstmid_restart_tick: got %0d want 256", n); end
        n = 0; do begin @(negedge clk); n++; end while (rnd_vld !== 1'b1 && n < 200);
        nvec++; if (rd_all !== exp_rd(12'h500)) begin nerr++; $display("FAIL rstmid_rd_all_after: got %h want %h", rd_all, exp_rd(12'h500)); end
        en = 1'b0;
    endtask

    task automatic test_overrun();
        int n;
        int s;
        int v;
        @(negedge clk);
        en2 = 1'b1;
        n = 0; do begin @(negedge clk); n++; end while (ir_en2 !== 1'b1 && n < 200);
        nvec++; if (n != 64) begin nerr++; $display("FAIL ovr_first_tick: got %0d want 64", n); end
        for (int r = 0; r < 3; r++) begin
            s = 0; v = 0;
            for (int k = 1; k < 128; k++) begin
                @(negedge clk);
                if (strt_cnv2 === 1'b1) s++;
                if (rnd_vld2 === 1'b1) v++;
            end
            nvec++; if (s != 4) begin nerr++; $display("FAIL ovr_strt_count%0d: got %0d want 4", r, s); end
            nvec++; if (v != 1) begin nerr++; $display("FAIL ovr_rnd_count%0d: got %0d want 1", r, v); end
            nvec++; if (ir_en2 !== 1'b0) begin nerr++; $display("FAIL ovr_idle%0d: got %b want 0", r, ir_en2); end
            nvec++; if (rd_all2 !== 48'h103_102_101_100) begin nerr++; $display("FAIL ovr_rd_all%0d: got %h want 103102101100", r, rd_all2); end
            @(negedge clk);
            nvec++; if (ir_en2 !== 1'b1) begin nerr++; $display("FAIL ovr_restart%0d: got %b want 1", r, ir_en2); end
        end
        en2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_normal();
        test_stale_cmplt();
        test_timeout();
        test_en_drop();
        test_reset_mid_round();
        test_overrun();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
